// File: rtl/zpaq_block_packer.sv
// zpaq_block_packer
//
// Packs the compress core's 8-bit AXI4-Stream into 64-bit little-endian
// words for the DDR/DMA writer. After the final data word of each block
// (marked by s_tlast) a trailer word {seq, byte_cnt} is appended with
// m_tlast=1 so the host can split and decode blocks.
//
// Ports:
//   clk       - single clock
//   reset_n   - asynchronous active-low reset
//   s_tdata   - input byte            s_tvalid/s_tready/s_tlast - input handshake
//   m_tdata   - packed word/trailer   m_tkeep - byte-lane enables
//   m_tvalid/m_tready - output handshake, m_tlast - high on trailer only
//   blk_seq   - number of trailers fully sent since reset
//   busy      - high when not idle in COLLECT at lane 0
module zpaq_block_packer #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    output logic [63:0]          m_tdata,
    output logic [7:0]           m_tkeep,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [CNT_W-1:0]     blk_seq,
    output logic                 busy
);

    typedef enum logic [1:0] {
        COLLECT      = 2'd0,
        EMIT_DATA    = 2'd1,
        EMIT_TRAILER = 2'd2
    } state_t;

    state_t             state_reg;
    logic [2:0]         lane_reg;
    logic [63:0]        acc_reg;
    logic [CNT_W-1:0]   byte_cnt_reg;
    logic [CNT_W-1:0]   seq_reg;
    logic               last_pending_reg;

    logic               in_hs;
    logic               out_hs;
    logic [63:0]        word_next;
    logic [7:0]         keep_next;
    logic [CNT_W-1:0]   seq_next;

    // s_tready depends only on state (never on s_tvalid) and is held low
    // while reset is asserted.
    assign s_tready = reset_n && (state_reg == COLLECT);
    assign in_hs    = s_tvalid && s_tready;
    assign out_hs   = m_tvalid && m_tready;
    assign busy     = (state_reg != COLLECT) || (lane_reg != 3'd0);
    assign seq_next = seq_reg + CNT_W'(1);

    // Merge the incoming byte into its lane; lanes above the current one
    // are still zero in the accumulator, so a short word is zero-padded.
    // keep_next covers lanes 0..lane (lane = value before increment).
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [2:0] LANE = 3'(gi);
            assign word_next[8*gi +: 8] = (lane_reg == LANE) ? s_tdata
                                                              : acc_reg[8*gi +: 8];
            assign keep_next[gi]        = (LANE <= lane_reg);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= COLLECT;
            lane_reg         <= 3'd0;
            acc_reg          <= 64'd0;
            byte_cnt_reg     <= '0;
            seq_reg          <= '0;
            last_pending_reg <= 1'b0;
            blk_seq          <= '0;
            m_tdata          <= 64'd0;
            m_tkeep          <= 8'd0;
            m_tvalid         <= 1'b0;
            m_tlast          <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (in_hs) begin
                        byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                        if ((lane_reg == 3'd7) || s_tlast) begin
                            // Word complete: hand it to the output register
                            // and restart collection from an empty accumulator.
                            m_tdata          <= word_next;
                            m_tkeep          <= keep_next;
                            m_tlast          <= 1'b0;
                            m_tvalid         <= 1'b1;
                            acc_reg          <= 64'd0;
                            lane_reg         <= 3'd0;
                            last_pending_reg <= s_tlast;
                            state_reg        <= EMIT_DATA;
                        end else begin
                            acc_reg  <= word_next;
                            lane_reg <= lane_reg + 3'd1;
                        end
                    end
                end

                EMIT_DATA: begin
                    if (out_hs) begin
                        if (last_pending_reg) begin
                            // No input is accepted while emitting, so
                            // byte_cnt is already the final block length.
                            m_tdata   <= {seq_reg, byte_cnt_reg};
                            m_tkeep   <= 8'hFF;
                            m_tlast   <= 1'b1;
                            state_reg <= EMIT_TRAILER;
                        end else begin
                            m_tvalid  <= 1'b0;
                            state_reg <= COLLECT;
                        end
                    end
                end

                EMIT_TRAILER: begin
                    if (out_hs) begin
                        seq_reg          <= seq_next;
                        blk_seq          <= seq_next;
                        byte_cnt_reg     <= '0;
                        last_pending_reg <= 1'b0;
                        m_tvalid         <= 1'b0;
                        m_tlast          <= 1'b0;
                        state_reg        <= COLLECT;
                    end
                end

                default: begin
                    state_reg <= COLLECT;
                    m_tvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zpaq_block_packer.sv
module tb_zpaq_block_packer;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [31:0] blk_seq;
    logic        busy;

    zpaq_block_packer #(.CNT_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .blk_seq  (blk_seq),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          tmo = 0;
    int          stall_err = 0;
    int          tready_pct = 100;
    bit          verbose = 1'b1;
    int          exp_seq = 0;
    beat_t       beats[$];
    beat_t       exp_q[$];
    logic [7:0]  blk[$];

    // Output monitor: choose m_tready for the coming edge, then record the
    // beat that edge will accept; also watch that a stalled beat holds.
    bit    stalled = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled && (m_tvalid !== 1'b1 || {m_tdata, m_tkeep, m_tlast} !== held))
                stall_err++;
            m_tready = ($urandom_range(99) < tready_pct);
            if (m_tvalid && m_tready) begin
                beats.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast});
                if (verbose)
                    $display("beat %0d: data=%016h keep=%02h last=%0b",
                             beats.size() - 1, m_tdata, m_tkeep, m_tlast);
                stalled = 1'b0;
            end else if (m_tvalid) begin
                stalled = 1'b1;
                held = '{d: m_tdata, k: m_tkeep, l: m_tlast};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Send every byte of blk; tlast on the final byte when with_last.
    task automatic send_block(input int gap_pct, input bit with_last);
        for (int i = 0; i < blk.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                s_tvalid = 1'b0;
                @(negedge clk);
            end
            s_tdata  = blk[i];
            s_tlast  = with_last && (i == blk.size() - 1);
            s_tvalid = 1'b1;
            begin
                int n = 0;
                while (s_tready !== 1'b1 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 5000) tmo++;
            end
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beats.size() < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) tmo++;
        repeat (2) @(negedge clk);
    endtask

    // Reference packer for the randomised test.
    task automatic model_block();
        logic [63:0] w = 64'd0;
        int lane = 0;
        for (int i = 0; i < blk.size(); i++) begin
            w[8*lane +: 8] = blk[i];
            if (lane == 7 || i == blk.size() - 1) begin
                exp_q.push_back('{d: w, k: 8'((9'd1 << (lane + 1)) - 9'd1), l: 1'b0});
                w = 64'd0;
                lane = 0;
            end else begin
                lane++;
            end
        end
        exp_q.push_back('{d: {32'(exp_seq), 32'(blk.size())}, k: 8'hFF, l: 1'b1});
        exp_seq++;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_seq = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_tvalid, m_tlast, busy, s_tready} !== 4'b0000)
            $display("FAIL reset_ctrl: valid/last/busy/ready=%b expected 0000",
                     {m_tvalid, m_tlast, busy, s_tready});
        else passes++;
        checks++;
        if ({m_tdata, m_tkeep} !== 72'd0)
            $display("FAIL reset_data: data=%016h keep=%02h expected 0", m_tdata, m_tkeep);
        else passes++;
        checks++;
        if (blk_seq !== 32'd0) $display("FAIL reset_blk_seq: got %0d expected 0", blk_seq);
        else passes++;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", s_tready);
        else passes++;
        exp_seq = 0;
    endtask

    task automatic test_full_word();
        tmo = 0; beats.delete(); tready_pct = 100;
        blk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_block(0, 1'b1);
        wait_beats(2);
        checks++;
        if (tmo !== 0 || beats.size() !== 2)
            $display("FAIL full_count: beats=%0d timeouts=%0d expected 2/0", beats.size(), tmo);
        else passes++;
        checks++;
        if (beats.size() > 0 && beats[0] !== '{d: 64'h0807060504030201, k: 8'hFF, l: 1'b0})
            $display("FAIL full_word: got %016h/%02h/%b expected 0807060504030201/ff/0",
                     beats[0].d, beats[0].k, beats[0].l);
        else passes++;
        checks++;
        if (beats.size() > 1 && beats[1] !== '{d: 64'h00000000_00000008, k: 8'hFF, l: 1'b1})
            $display("FAIL full_trailer: got %016h/%02h/%b expected 0000000000000008/ff/1",
                     beats[1].d, beats[1].k, beats[1].l);
        else passes++;
        checks++;
        if (blk_seq !== 32'd1) $display("FAIL full_blk_seq: got %0d expected 1", blk_seq);
        else passes++;
    endtask

    task automatic test_partial_word();
        tmo = 0; beats.delete(); tready_pct = 100;
        blk = '{8'hA0, 8'hA1, 8'hA2};
        send_block(0, 1'b1);
        wait_beats(2);
        checks++;
        if (tmo !== 0 || beats.size() !== 2)
            $display("FAIL partial_count: beats=%0d timeouts=%0d expected 2/0", beats.size(), tmo);
        else passes++;
        checks++;
        if (beats.size() > 0 && beats[0] !== '{d: 64'h0000000000A2A1A0, k: 8'h07, l: 1'b0})
            $display("FAIL partial_word: got %016h/%02h/%b expected 0000000000a2a1a0/07/0",
                     beats[0].d, beats[0].k, beats[0].l);
        else passes++;
        checks++;
        if (beats.size() > 1 && beats[1] !== '{d: 64'h00000001_00000003, k: 8'hFF, l: 1'b1})
            $display("FAIL partial_trailer: got %016h/%02h/%b expected 0000000100000003/ff/1",
                     beats[1].d, beats[1].k, beats[1].l);
        else passes++;
    endtask

    // Single byte with the output stalled: word appears one cycle after
    // the byte, input is blocked, and the word holds until accepted.
    task automatic test_single_byte_backpressure();
        tmo = 0; beats.delete(); tready_pct = 0;
        @(negedge clk);
        blk = '{8'h5A};
        send_block(0, 1'b1);
        checks++;
        if ({m_tvalid, s_tready, busy} !== 3'b101)
            $display("FAIL bp_latency: valid/ready/busy=%b expected 101", {m_tvalid, s_tready, busy});
        else passes++;
        repeat (4) @(negedge clk);
        checks++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== {1'b1, 64'h5A, 8'h01, 1'b0})
            $display("FAIL bp_hold: valid=%b data=%016h keep=%02h last=%b expected 1/5a/01/0",
                     m_tvalid, m_tdata, m_tkeep, m_tlast);
        else passes++;
        tready_pct = 100;
        wait_beats(2);
        checks++;
        if (tmo !== 0 || beats.size() !== 2)
            $display("FAIL single_count: beats=%0d timeouts=%0d expected 2/0", beats.size(), tmo);
        else passes++;
        checks++;
        if (beats.size() > 1 && beats[1] !== '{d: 64'h00000002_00000001, k: 8'hFF, l: 1'b1})
            $display("FAIL single_trailer: got %016h/%02h/%b expected 0000000200000001/ff/1",
                     beats[1].d, beats[1].k, beats[1].l);
        else passes++;
        checks++;
        if (blk_seq !== 32'd3) $display("FAIL single_blk_seq: got %0d expected 3", blk_seq);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        pulse_reset();
        tmo = 0; beats.delete(); tready_pct = 100; verbose = 1'b0;
        blk.delete();
        for (int i = 0; i < 4096; i++) blk.push_back(8'(i));
        send_block(0, 1'b1);
        blk = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_block(0, 1'b1);
        wait_beats(515);
        verbose = 1'b1;
        $display("back_to_back: %0d beats received", beats.size());
        checks++;
        if (tmo !== 0 || beats.size() !== 515)
            $display("FAIL b2b_count: beats=%0d timeouts=%0d expected 515/0", beats.size(), tmo);
        else passes++;
        if (beats.size() == 515) begin
            for (int w = 0; w < 512; w++) begin
                logic [63:0] e;
                for (int b = 0; b < 8; b++) e[8*b +: 8] = 8'(w * 8 + b);
                if (beats[w] !== '{d: e, k: 8'hFF, l: 1'b0}) bad++;
            end
            checks++;
            if (bad !== 0) $display("FAIL b2b_words: %0d bad words expected 0", bad);
            else passes++;
            checks++;
            if (beats[512] !== '{d: 64'h00000000_00001000, k: 8'hFF, l: 1'b1})
                $display("FAIL b2b_trailer0: got %016h/%02h/%b expected 0000000000001000/ff/1",
                         beats[512].d, beats[512].k, beats[512].l);
            else passes++;
            checks++;
            if (beats[513] !== '{d: 64'h000000C4C3C2C1C0, k: 8'h1F, l: 1'b0})
                $display("FAIL b2b_short: got %016h/%02h/%b expected 000000c4c3c2c1c0/1f/0",
                         beats[513].d, beats[513].k, beats[513].l);
            else passes++;
            checks++;
            if (beats[514] !== '{d: 64'h00000001_00000005, k: 8'hFF, l: 1'b1})
                $display("FAIL b2b_trailer1: got %016h/%02h/%b expected 0000000100000005/ff/1",
                         beats[514].d, beats[514].k, beats[514].l);
            else passes++;
        end
    endtask

    task automatic test_random();
        pulse_reset();
        tmo = 0; beats.delete(); exp_q.delete(); stall_err = 0; tready_pct = 70;
        for (int b = 0; b < 10; b++) begin
            int len = $urandom_range(1, 40);
            blk.delete();
            for (int i = 0; i < len; i++) blk.push_back(8'($urandom_range(255)));
            model_block();
            send_block(30, 1'b1);
        end
        wait_beats(exp_q.size());
        checks++;
        if (tmo !== 0 || beats.size() !== exp_q.size())
            $display("FAIL rand_count: beats=%0d timeouts=%0d expected %0d/0",
                     beats.size(), tmo, exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== exp_q[i])
                $display("FAIL rand_beat%0d: got %016h/%02h/%b expected %016h/%02h/%b", i,
                         beats[i].d, beats[i].k, beats[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            else passes++;
        end
        checks++;
        if (stall_err !== 0) $display("FAIL rand_stall_stable: %0d violations expected 0", stall_err);
        else passes++;
        checks++;
        if (blk_seq !== 32'd10) $display("FAIL rand_blk_seq: got %0d expected 10", blk_seq);
        else passes++;
        tready_pct = 100;
    endtask

    task automatic test_reset_mid_block();
        tmo = 0; beats.delete(); tready_pct = 100;
        blk = '{8'hE1, 8'hE2, 8'hE3};
        send_block(0, 1'b0);
        checks++;
        if (busy !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", busy);
        else passes++;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({s_tready, m_tvalid, blk_seq} !== {1'b0, 1'b0, 32'd0})
            $display("FAIL midrst_in_reset: ready=%b valid=%b blk_seq=%0d expected 0/0/0",
                     s_tready, m_tvalid, blk_seq);
        else passes++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (beats.size() !== 0) $display("FAIL midrst_no_output: beats=%0d expected 0", beats.size());
        else passes++;
        blk = '{8'h11, 8'h22};
        send_block(0, 1'b1);
        wait_beats(2);
        checks++;
        if (tmo !== 0 || beats.size() !== 2)
            $display("FAIL midrst_count: beats=%0d timeouts=%0d expected 2/0", beats.size(), tmo);
        else passes++;
        checks++;
        if (beats.size() > 0 && beats[0] !== '{d: 64'h0000000000002211, k: 8'h03, l: 1'b0})
            $display("FAIL midrst_word: got %016h/%02h/%b expected 0000000000002211/03/0",
                     beats[0].d, beats[0].k, beats[0].l);
        else passes++;
        checks++;
        if (beats.size() > 1 && beats[1] !== '{d: 64'h00000000_00000002, k: 8'hFF, l: 1'b1})
            $display("FAIL midrst_trailer: got %016h/%02h/%b expected 0000000000000002/ff/1",
                     beats[1].d, beats[1].k, beats[1].l);
        else passes++;
    endtask

    initial begin
        reset_n  = 1'b0;
        s_tdata  = 8'd0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        test_reset();
        test_full_word();
        test_partial_word();
        test_single_byte_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_block();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
